sample_source: RTL and testbench

SAMPLE_SOURCE -- requirements
Module: sample_source

---
 rtl/synth_pkg.sv | 20 ++
 rtl/wave_shape.sv | 26 ++
 rtl/sample_source.sv | 115 +++++++++++
 tb/tb_sample_source.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared encodings for the tone synthesizer blocks: waveform select codes
// and the sample source state machine states.
package synth_pkg;

  typedef logic [1:0] wave_sel_t;
  typedef logic [1:0] state_t;

  localparam wave_sel_t WAVE_SQUARE = 2'b00;
  localparam wave_sel_t WAVE_SAW    = 2'b01;
  localparam wave_sel_t WAVE_TRI    = 2'b10;
  localparam wave_sel_t WAVE_SILENT = 2'b11;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_STOPPING = 2'd2;

  localparam logic signed [15:0] SQ_POS = 16'sd32767;
  localparam logic signed [15:0] SQ_NEG = -16'sd32767;

endpackage

// File: rtl/wave_shape.sv
// Combinational map from the top 16 phase bits and the waveform select
// to a signed 16-bit sample.
module wave_shape
  import synth_pkg::*;
(
  input  logic [15:0]        p16,
  input  wave_sel_t          wave_sel,
  output logic signed [15:0] sample
);

  logic [15:0] t;
  logic [15:0] tri_v;

  always_comb begin
    t     = {p16[14:0], 1'b0};
    // Second half of the cycle mirrors the rising ramp into a falling one.
    tri_v = p16[15] ? ~(t ^ 16'h8000) : (t ^ 16'h8000);
    case (wave_sel)
      WAVE_SQUARE: sample = p16[15] ? SQ_NEG : SQ_POS;
      WAVE_SAW:    sample = $signed(p16 ^ 16'h8000);
      WAVE_TRI:    sample = $signed(tri_v);
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/sample_source.sv
// Phase-accumulator tone source: emits one signed sample per SAMPLE_DIV
// clocks and stops cleanly at a phase wrap once play_enable drops.
module sample_source
  import synth_pkg::*;
#(
  parameter int SAMPLE_DIV = 2,
  parameter int PHASE_W    = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic               load_step,
  input  logic [PHASE_W-1:0] step_in,
  input  logic [1:0]         wave_sel,
  output logic [15:0]        sample_out,
  output logic               in_ready,
  output logic               active
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [15:0]        sample_q, sample_d;
  logic               in_ready_q, in_ready_d;
  state_t             state_q, state_d;

  logic               strobe;
  logic               wrap;
  logic [PHASE_W-1:0] phase_nxt;
  logic signed [15:0] shaped;

  assign phase_nxt = phase_q + step_q;

  wave_shape u_wave_shape (
    .p16      (phase_nxt[PHASE_W-1 -: 16]),
    .wave_sel (wave_sel),
    .sample   (shaped)
  );

  always_comb begin
    strobe     = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d      = strobe ? '0 : cnt_q + 1'b1;
    in_ready_d = strobe;
    wrap       = phase_q[PHASE_W-1] & ~phase_nxt[PHASE_W-1];
    state_d    = state_q;
    phase_d    = phase_q;
    step_d     = step_q;
    sample_d   = sample_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe) sample_d = '0;
        if (play_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (strobe) begin
          phase_d  = phase_nxt;
          sample_d = shaped;
        end
        if (!play_enable) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (play_enable) begin
          state_d = ST_RUN;
          if (strobe) begin
            phase_d  = phase_nxt;
            sample_d = shaped;
          end
        end else if (strobe) begin
          // Stop only at the MSB 1->0 crossing so the tone ends on a cycle boundary.
          if (wrap) begin
            phase_d  = '0;
            sample_d = '0;
            state_d  = ST_IDLE;
          end else begin
            phase_d  = phase_nxt;
            sample_d = shaped;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The step register update is invisible to this edge's strobe, which used step_q.
    if (load_step) begin
      step_d = step_in;
      if (state_q == ST_IDLE) phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      step_q     <= '0;
      sample_q   <= '0;
      in_ready_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      sample_q   <= sample_d;
      in_ready_q <= in_ready_d;
      state_q    <= state_d;
    end
  end

  assign sample_out = sample_q;
  assign in_ready   = in_ready_q;
  assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sample_source.sv
// Directed bench for sample_source with SAMPLE_DIV=2, PHASE_W=20.
module tb_sample_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_step;
  logic [19:0] step_in;
  logic [1:0]  wave_sel;
  logic [15:0] sample_out;
  logic        in_ready;
  logic        active;

  int checks = 0;
  int fails  = 0;

  sample_source #(.SAMPLE_DIV(2), .PHASE_W(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .play_enable (play_enable),
    .load_step   (load_step),
    .step_in     (step_in),
    .wave_sel    (wave_sel),
    .sample_out  (sample_out),
    .in_ready    (in_ready),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until in_ready is seen (bounded), then check the new sample.
  task automatic strobe_chk(input string tag, input int exp);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (in_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $error("FAIL %s_timeout observed=no_strobe expected=strobe", tag);
    end else begin
      chk(tag, $signed(sample_out), exp);
    end
  endtask

  function automatic int sq_exp(input int k);
    return ((k % 32) < 16) ? 32767 : -32767;
  endfunction

  function automatic int saw_exp(input int k);
    return -32768 + (k % 32) * 2048;
  endfunction

  function automatic int tri_exp(input int k);
    int p;
    p = (k * 2048) % 65536;
    return (p < 32768) ? (-32768 + 2 * p) : (32767 - 2 * (p - 32768));
  endfunction

  initial begin
    reset = 1'b1; play_enable = 1'b0; load_step = 1'b0;
    step_in = '0; wave_sel = 2'b00;
    repeat (4) cyc();
    chk("rst_sample", $signed(sample_out), 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_active", active, 0);

    // Release: in_ready 0,1,0,1 with silent samples.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rel_in_ready", in_ready, (i % 2));
      chk("rel_sample", $signed(sample_out), 0);
    end

    // Square, p16 step 0x0800 per strobe.
    load_step = 1'b1; step_in = 20'h08000; wave_sel = 2'b00; play_enable = 1'b1;
    cyc();
    load_step = 1'b0;
    chk("sq_active", active, 1);
    for (int k = 1; k <= 72; k++) strobe_chk("square", sq_exp(k));

    // Stop: continues until wrap at k=96, then one zero and IDLE.
    play_enable = 1'b0;
    for (int k = 73; k <= 95; k++) strobe_chk("stop_tail", sq_exp(k));
    chk("stopping_active", active, 1);
    strobe_chk("stop_zero", 0);
    chk("stop_active", active, 0);
    for (int i = 0; i < 3; i++) strobe_chk("idle_zero", 0);

    // Saw from IDLE; phase cleared by load_step.
    load_step = 1'b1; step_in = 20'h08000; wave_sel = 2'b01; play_enable = 1'b1;
    cyc();
    load_step = 1'b0;
    for (int k = 1; k <= 33; k++) strobe_chk("saw", saw_exp(k));

    // Switch to triangle without phase reset.
    wave_sel = 2'b10;
    for (int k = 34; k <= 65; k++) strobe_chk("tri", tri_exp(k));

    // load_step on the strobe edge: old step applies, new step next.
    wave_sel = 2'b01;
    cyc();
    load_step = 1'b1; step_in = 20'h10000;
    cyc();
    load_step = 1'b0;
    chk("ld_coinc_strobe", in_ready, 1);
    chk("ld_coinc_old", $signed(sample_out), -28672);
    strobe_chk("ld_new1", -24576);
    strobe_chk("ld_new2", -20480);

    // Reset while STOPPING.
    play_enable = 1'b0;
    cyc();
    chk("pre_rst_active", active, 1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_sample", $signed(sample_out), 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_rdy0", in_ready, 0);
    cyc();
    chk("post_rst_rdy1", in_ready, 1);
    chk("post_rst_sample", $signed(sample_out), 0);

    // Zero step: same sample repeats, STOPPING never wraps out.
    load_step = 1'b1; step_in = '0; wave_sel = 2'b01; play_enable = 1'b1;
    cyc();
    load_step = 1'b0;
    for (int i = 0; i < 3; i++) strobe_chk("step0_run", -32768);
    play_enable = 1'b0;
    for (int i = 0; i < 3; i++) strobe_chk("step0_stop", -32768);
    chk("step0_active", active, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
